// File: rtl/module_bcdtobin.sv
// rtl/module_bcdtobin.sv - sequential BCD-to-binary converter (reverse double-dabble, one bit per clock)
module module_bcdtobin #(
  parameter int NDIGITS   = 2,
  parameter int WIDTH_OUT = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  output logic [WIDTH_OUT-1:0]   bin_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int BCD_W = 4 * NDIGITS;
  localparam int SR_W  = BCD_W + WIDTH_OUT;
  localparam int CNT_W = $clog2(WIDTH_OUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_shift;
  logic [SR_W-1:0]  sr_step;
  logic [CNT_W-1:0] cnt;
  logic             invalid;
  logic             bcd_bad;
  logic             last_shift;

  assign last_shift = (cnt == CNT_W'(WIDTH_OUT - 1));

  always_comb begin
    bcd_bad = 1'b0;
    for (int d = 0; d < NDIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) begin
        bcd_bad = 1'b1;
      end
    end
  end

  // Shift right, then correct every decimal field that now reads 8 or more.
  always_comb begin
    sr_shift = sr >> 1;
    sr_step  = sr_shift;
    for (int d = 0; d < NDIGITS; d++) begin
      if (sr_shift[WIDTH_OUT + 4*d + 3]) begin
        sr_step[WIDTH_OUT + 4*d +: 4] = sr_shift[WIDTH_OUT + 4*d +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CONV;
      S_CONV:  if (last_shift) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_CONV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      cnt     <= '0;
      invalid <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sr      <= {bcd_in, {WIDTH_OUT{1'b0}}};
            invalid <= bcd_bad;
            cnt     <= '0;
          end
        end
        S_CONV: begin
          sr  <= sr_step;
          cnt <= cnt + CNT_W'(1);
        end
        S_DONE: begin
          bin_out <= invalid ? '0 : sr[WIDTH_OUT-1:0];
          err     <= invalid;
          done    <= 1'b1;
        end
        default: begin
          sr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_bcdtobin.sv
// tb/tb_module_bcdtobin.sv - scoreboard bench for module_bcdtobin (2-digit and 3-digit instances)
module tb_module_bcdtobin;

  typedef struct {
    int bin;
    int err;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  bcd_in;
  logic [6:0]  bin_out;
  logic        busy, done, err;

  logic        start3;
  logic [11:0] bcd3;
  logic [9:0]  bin3;
  logic        busy3, done3, err3;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  exp_t q[$];
  exp_t q3[$];

  module_bcdtobin #(.NDIGITS(2), .WIDTH_OUT(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .bin_out(bin_out), .busy(busy), .done(done), .err(err)
  );

  module_bcdtobin #(.NDIGITS(3), .WIDTH_OUT(10)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .bcd_in(bcd3),
    .bin_out(bin3), .busy(busy3), .done(done3), .err(err3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Decimal meaning of a packed BCD word; any digit above 9 makes it an error with result 0.
  function automatic exp_t model(input logic [11:0] b, input int nd, input int c);
    exp_t e;
    int   v;
    int   bad;
    v = 0;
    bad = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      if (b[4*i +: 4] > 4'd9) bad = 1;
      v = v * 10 + int'(b[4*i +: 4]);
    end
    e.bin = bad ? 0 : v;
    e.err = bad;
    e.cyc = c;
    return e;
  endfunction

  int busy_run = 0, last_run = 0, prev_err = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
      last_run = 0;
      prev_err = 0;
    end else begin
      if (busy) busy_run++;
      else if (busy_run > 0) begin
        last_run = busy_run;
        busy_run = 0;
      end
      if (done && busy) chk("done_with_busy", 1, 0);
      if (int'(err) != prev_err && !done) chk("err_changed_without_done", int'(err), prev_err);
      prev_err = int'(err);
      if (done) begin
        done_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("bin_out", int'(bin_out), e.bin);
          chk("err", int'(err), e.err);
          chk("latency", cyc - e.cyc, 8);
          chk("busy_cycles", last_run, 7);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done3) begin
      if (q3.size() == 0) begin
        chk("unexpected_done3", 1, 0);
      end else begin
        e = q3.pop_front();
        if (int'(bin3) != e.bin || int'(err3) != e.err || cyc - e.cyc != 11) begin
          chk("sweep_bin3", int'(bin3), e.bin);
          chk("sweep_err3", int'(err3), e.err);
          chk("sweep_latency3", cyc - e.cyc, 11);
        end else begin
          n_vec++;
        end
      end
    end
  end

  task automatic issue(input logic [7:0] b);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = b;
    @(posedge clk);
    #1;
    q.push_back(model({4'd0, b}, 2, cyc));
    start  = 1'b0;
    bcd_in = 8'($urandom);
  endtask

  task automatic wait_empty();
    for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
    if (q.size() != 0) begin
      chk("timeout_waiting_done", 0, 1);
      q.delete();
    end
  endtask

  task automatic wait_done_edge();
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!done) chk("timeout_back_to_back", 0, 1);
  endtask

  initial begin
    logic [7:0]  b;
    logic [7:0]  cur;
    logic [11:0] b3;
    int          d0;

    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 8'h00;
    start3 = 1'b0;
    bcd3   = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bin_out", int'(bin_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(8'h42);
    wait_empty();

    issue(8'h99);
    wait_done_edge();
    start  = 1'b1;
    bcd_in = 8'h00;
    @(posedge clk);
    #1;
    q.push_back(model(12'h000, 2, cyc));
    start = 1'b0;
    wait_empty();

    issue(8'h3A);
    wait_empty();
    issue(8'h15);
    wait_empty();

    // Starts while busy and in the post-conversion cycle must be ignored.
    d0 = done_cnt;
    issue(8'h27);
    repeat (2) @(negedge clk);
    start  = 1'b1;
    bcd_in = 8'h88;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 50 && busy; t++) @(negedge clk);
    start  = 1'b1;
    bcd_in = 8'h88;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("single_done_for_ignored_starts", done_cnt - d0, 1);
    wait_empty();

    issue(8'h64);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_bin_out", int'(bin_out), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_done", int'(done), 0);
    chk("async_reset_err", int'(err), 0);
    q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (15) @(negedge clk);
    chk("no_done_after_abort", done_cnt - d0, 0);
    issue(8'h64);
    wait_empty();

    // Held-high start retriggers every WIDTH_OUT+2 cycles; each run uses the word seen at its accepting edge.
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (i != 0) @(negedge clk);
      bcd_in = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      cur = bcd_in;
      @(posedge clk);
      #1;
      if (i % 9 == 0) q.push_back(model({4'd0, cur}, 2, cyc));
    end
    @(negedge clk);
    start = 1'b0;
    wait_empty();

    for (int n = 0; n < 150; n++) begin
      b[3:0] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      b[7:4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      issue(b);
      wait_empty();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int v = 0; v < 1000; v++) begin
      b3 = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      @(negedge clk);
      start3 = 1'b1;
      bcd3   = b3;
      @(posedge clk);
      #1;
      q3.push_back(model(b3, 3, cyc));
      start3 = 1'b0;
      bcd3   = 12'($urandom);
      for (int t = 0; t < 100 && q3.size() != 0; t++) @(negedge clk);
      if (q3.size() != 0) begin
        chk("timeout_sweep", 0, 1);
        q3.delete();
      end
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size() + q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
